// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit computer core.
// Holds the program-loader state encoding, the RAM geometry and the uio
// output-enable patterns used while programming and while running.
package eater_pkg;

   localparam int unsigned EATER_ADDR_W = 4;
   localparam int unsigned EATER_DATA_W = 8;

   localparam logic [7:0] UIO_OE_RUN  = 8'hFF;
   localparam logic [7:0] UIO_OE_PROG = 8'h00;

   typedef enum logic [2:0] {
      RUN,
      PROG_IDLE,
      PRESS_DB,
      WRITE,
      RELEASE_DB,
      EXIT
   } prog_state_t;

endpackage

// File: rtl/input_sync.sv
// Multi-bit, multi-stage flop synchronizer for slow asynchronous inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input bundle
//   q     - synchronized bundle, STAGES cycles behind d
// Bits are synchronized independently, so callers must tolerate skew
// between bits of the bundle.
module input_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader for the 8-bit computer core.
// Synchronizes the program-mode switch, address/data switches and write
// button, debounces the button and issues one handshaked RAM write per press.
// Halts the CPU while programming and pulses a CPU restart on exit.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   prog_mode_in      - async program-mode switch
//   addr_in, data_in  - async address / data switches
//   wr_btn_in         - async write push-button
//   ram_ready         - RAM accepts the write in a cycle with ram_we high
//   ram_we            - write request, held until accepted
//   ram_addr/wdata    - write address/data, stable while ram_we is high
//   cpu_halt          - high while in program mode (including the exit cycle)
//   cpu_reset_req     - one-cycle restart pulse on leaving program mode
//   uio_oe_ctrl       - uio direction: all inputs while programming
//   write_count       - writes completed this programming session, saturating
module prog_loader
   import eater_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned ADDR_W          = EATER_ADDR_W,
   parameter int unsigned DATA_W          = EATER_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_mode_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              wr_btn_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ram_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              cpu_halt,
   output logic              cpu_reset_req,
   output logic [7:0]        uio_oe_ctrl,
   output logic [4:0]        write_count
);

   localparam int unsigned SYNC_W = 2 + ADDR_W + DATA_W;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchronized inputs
   logic              prog_mode_s;
   logic              wr_btn_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;

   // addr/data skew against the button is harmless: they are only sampled
   // after the button has been stable for a full debounce window.
   input_sync #(
      .WIDTH  (SYNC_W),
      .STAGES (SYNC_STAGES)
   ) u_input_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({prog_mode_in, wr_btn_in, addr_in, data_in}),
      .q     ({prog_mode_s, wr_btn_s, addr_s, data_s})
   );

   prog_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              halt_q, halt_d;
   logic              rst_req_q, rst_req_d;
   logic [7:0]        oe_q, oe_d;
   logic [4:0]        wcnt_q, wcnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         halt_q    <= 1'b0;
         rst_req_q <= 1'b0;
         oe_q      <= UIO_OE_RUN;
         wcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         halt_q    <= halt_d;
         rst_req_q <= rst_req_d;
         oe_q      <= oe_d;
         wcnt_q    <= wcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      halt_d    = halt_q;
      rst_req_d = 1'b0;
      oe_d      = oe_q;
      wcnt_d    = wcnt_q;

      unique case (state_q)
         RUN: begin
            if (prog_mode_s) begin
               state_d = PROG_IDLE;
               halt_d  = 1'b1;
               oe_d    = UIO_OE_PROG;
               wcnt_d  = '0;
            end
         end

         PROG_IDLE: begin
            if (!prog_mode_s) begin
               state_d   = EXIT;
               rst_req_d = 1'b1;
            end else if (wr_btn_s) begin
               state_d = PRESS_DB;
               cnt_d   = '0;
            end
         end

         PRESS_DB: begin
            if (!prog_mode_s) begin
               state_d   = EXIT;
               rst_req_d = 1'b1;
            end else if (!wr_btn_s) begin
               state_d = PROG_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = WRITE;
               we_d    = 1'b1;
               addr_d  = addr_s;
               wdata_d = data_s;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WRITE: begin
            // Leaving program mode waits for the in-flight write to land.
            if (we_q && ram_ready) begin
               we_d   = 1'b0;
               cnt_d  = '0;
               wcnt_d = (wcnt_q == 5'd31) ? wcnt_q : wcnt_q + 5'd1;
               if (!prog_mode_s) begin
                  state_d   = EXIT;
                  rst_req_d = 1'b1;
               end else begin
                  state_d = RELEASE_DB;
               end
            end
         end

         RELEASE_DB: begin
            if (!prog_mode_s) begin
               state_d   = EXIT;
               rst_req_d = 1'b1;
            end else if (wr_btn_s) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PROG_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         EXIT: begin
            // Always one cycle, even if the switch is back on already.
            state_d = RUN;
            halt_d  = 1'b0;
            oe_d    = UIO_OE_RUN;
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign ram_we        = we_q;
   assign ram_addr      = addr_q;
   assign ram_wdata     = wdata_q;
   assign cpu_halt      = halt_q;
   assign cpu_reset_req = rst_req_q;
   assign uio_oe_ctrl   = oe_q;
   assign write_count   = wcnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a short debounce window.
// Expected writes are queued when a press is driven and compared when the
// RAM handshake completes.
module tb_prog_loader;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              prog_mode_in = 1'b0;
   logic [ADDR_W-1:0] addr_in = '0;
   logic              wr_btn_in = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              ram_ready = 1'b0;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              cpu_halt;
   logic              cpu_reset_req;
   logic [7:0]        uio_oe_ctrl;
   logic [4:0]        write_count;

   int checks = 0;
   int errors = 0;
   int we_cycles = 0;
   int rst_req_cycles = 0;
   logic [ADDR_W+DATA_W-1:0] sb_q[$];

   prog_loader #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .ADDR_W          (ADDR_W),
      .DATA_W          (DATA_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .prog_mode_in  (prog_mode_in),
      .addr_in       (addr_in),
      .wr_btn_in     (wr_btn_in),
      .data_in       (data_in),
      .ram_ready     (ram_ready),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .cpu_halt      (cpu_halt),
      .cpu_reset_req (cpu_reset_req),
      .uio_oe_ctrl   (uio_oe_ctrl),
      .write_count   (write_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: a transfer happens on the edge after a cycle with we && ready.
   always @(negedge clk) begin
      if (rst_n && ram_we) begin
         we_cycles++;
         if (ram_ready) begin
            check_eq("sb_depth", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               logic [ADDR_W+DATA_W-1:0] exp_w;
               exp_w = sb_q.pop_front();
               check_eq("wr_addr", 32'(ram_addr), 32'(exp_w[ADDR_W+DATA_W-1:DATA_W]));
               check_eq("wr_data", 32'(ram_wdata), 32'(exp_w[DATA_W-1:0]));
            end
         end
      end
      if (rst_n && cpu_reset_req) rst_req_cycles++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_we(input string tag);
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (ram_we) break;
      end
      check_eq(tag, 32'(ram_we), 1);
   endtask

   task automatic wait_halt(input string tag);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (cpu_halt) break;
      end
      check_eq(tag, 32'(cpu_halt), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      int rq0;

      // Reset with random inputs
      for (int i = 0; i < 6; i++) begin
         prog_mode_in = 1'($urandom);
         wr_btn_in    = 1'($urandom);
         addr_in      = ADDR_W'($urandom);
         data_in      = DATA_W'($urandom);
         ram_ready    = 1'($urandom);
         tick(1);
      end
      check_eq("rst_we", 32'(ram_we), 0);
      check_eq("rst_halt", 32'(cpu_halt), 0);
      check_eq("rst_req", 32'(cpu_reset_req), 0);
      check_eq("rst_wcnt", 32'(write_count), 0);
      check_eq("rst_oe", 32'(uio_oe_ctrl), 32'h0FF);

      prog_mode_in = 1'b1;
      wr_btn_in    = 1'b0;
      addr_in      = 4'h3;
      data_in      = 8'hA5;
      ram_ready    = 1'b1;
      rst_n        = 1'b1;
      wait_halt("enter_halt");
      check_eq("enter_oe", 32'(uio_oe_ctrl), 32'h000);
      tick(3);

      // Single write with exact request latency, button held 20 cycles
      we0 = we_cycles;
      sb_q.push_back({4'h3, 8'hA5});
      wr_btn_in = 1'b1;
      tick(6);
      check_eq("lat_early", 32'(ram_we), 0);
      tick(1);
      check_eq("lat_rise", 32'(ram_we), 1);
      tick(13);
      wr_btn_in = 1'b0;
      tick(10);
      check_eq("single_we_cycles", 32'(we_cycles - we0), 1);
      check_eq("single_wcnt", 32'(write_count), 1);

      // Short glitch is rejected
      we0 = we_cycles;
      wr_btn_in = 1'b1;
      tick(2);
      wr_btn_in = 1'b0;
      tick(8);
      check_eq("glitch_we_cycles", 32'(we_cycles - we0), 0);

      // Second write, then a bouncy release
      addr_in = 4'h4;
      data_in = 8'h1C;
      tick(4);
      sb_q.push_back({4'h4, 8'h1C});
      wr_btn_in = 1'b1;
      tick(12);
      wr_btn_in = 1'b0;
      tick(2);
      wr_btn_in = 1'b1;
      tick(1);
      wr_btn_in = 1'b0;
      tick(12);
      check_eq("bounce_we_cycles", 32'(we_cycles - we0), 1);
      check_eq("bounce_wcnt", 32'(write_count), 2);

      // Back-pressure: data changes while the request waits
      addr_in   = 4'h5;
      data_in   = 8'hA5;
      ram_ready = 1'b0;
      tick(4);
      we0 = we_cycles;
      sb_q.push_back({4'h5, 8'hA5});
      wr_btn_in = 1'b1;
      wait_we("bp_we_seen");
      data_in = 8'hFF;
      tick(2);
      check_eq("bp_hold_data", 32'(ram_wdata), 32'h0A5);
      tick(1);
      ram_ready = 1'b1;
      tick(1);
      check_eq("bp_we_drop", 32'(ram_we), 0);
      wr_btn_in = 1'b0;
      tick(10);
      check_eq("bp_we_cycles", 32'(we_cycles - we0), 4);
      check_eq("bp_wcnt", 32'(write_count), 3);

      // Leave program mode while the write is stalled
      ram_ready = 1'b0;
      addr_in   = 4'h6;
      data_in   = 8'h3C;
      tick(4);
      rq0 = rst_req_cycles;
      sb_q.push_back({4'h6, 8'h3C});
      wr_btn_in = 1'b1;
      wait_we("exit_we_seen");
      prog_mode_in = 1'b0;
      tick(4);
      check_eq("exit_we_held", 32'(ram_we), 1);
      check_eq("exit_no_req_yet", 32'(cpu_reset_req), 0);
      ram_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (cpu_reset_req) break;
      end
      check_eq("exit_req", 32'(cpu_reset_req), 1);
      check_eq("exit_halt", 32'(cpu_halt), 1);
      check_eq("exit_wcnt", 32'(write_count), 4);
      tick(1);
      check_eq("run_req", 32'(cpu_reset_req), 0);
      check_eq("run_halt", 32'(cpu_halt), 0);
      check_eq("run_oe", 32'(uio_oe_ctrl), 32'h0FF);
      wr_btn_in = 1'b0;
      tick(3);
      check_eq("req_pulse_len", 32'(rst_req_cycles - rq0), 1);
      check_eq("sb_drained", 32'(sb_q.size()), 0);

      // Re-enter program mode, then reset mid-write
      prog_mode_in = 1'b1;
      ram_ready    = 1'b0;
      addr_in      = 4'h7;
      data_in      = 8'h99;
      tick(5);
      check_eq("reenter_halt", 32'(cpu_halt), 1);
      check_eq("reenter_wcnt", 32'(write_count), 0);
      wr_btn_in = 1'b1;
      wait_we("rst_we_seen");
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_we", 32'(ram_we), 0);
      check_eq("async_rst_halt", 32'(cpu_halt), 0);
      check_eq("async_rst_oe", 32'(uio_oe_ctrl), 32'h0FF);
      prog_mode_in = 1'b0;
      wr_btn_in    = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check_eq("post_rst_halt", 32'(cpu_halt), 0);
      check_eq("post_rst_we", 32'(ram_we), 0);
      prog_mode_in = 1'b1;
      wait_halt("post_rst_enter");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the 8-bit computer core: turns the slow, asynchronous front-panel programming inputs into clean, single-shot RAM write transactions.
- Synchronizes the prog-mode switch, address and data inputs; debounces the write button; issues one handshaked write per press.
- Halts the CPU while programming; requests a CPU restart on exit from program mode.
- Owns the uio direction control: inputs while programming, outputs while running.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer chain (≥2).
- DEBOUNCE_CYCLES, 1024, consecutive stable cycles required on press and on release (≥2); counter width = clog2(DEBOUNCE_CYCLES).
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prog_mode_in  in  1  async program-mode switch (ui_in[0])
- addr_in  in  ADDR_W  async RAM address switches (ui_in[4:1])
- wr_btn_in  in  1  async write push-button (ui_in[5])
- data_in  in  DATA_W  async data switches (uio_in)
- ram_ready  in  1  RAM accepts write this cycle when high with ram_we
- ram_we  out  1  write request
- ram_addr  out  ADDR_W  write address, stable while ram_we
- ram_wdata  out  DATA_W  write data, stable while ram_we
- cpu_halt  out  1  holds CPU clock-enable low
- cpu_reset_req  out  1  one-cycle CPU restart pulse
- uio_oe_ctrl  out  8  0x00 when programming, 0xFF when running
- write_count  out  5  writes completed since entering program mode, saturates at 31

Behaviour:
- Reset: async, immediate. State RUN. ram_we=0, ram_addr=0, ram_wdata=0, cpu_halt=0, cpu_reset_req=0, write_count=0, uio_oe_ctrl=0xFF. Synchronizer flops reset to 0.
- Inputs: every async input passes through SYNC_STAGES flops. The *_s versions below are the synchronized signals. addr/data are sampled only from *_s.
- FSM states: RUN, PROG_IDLE, PRESS_DB, WRITE, RELEASE_DB, EXIT. All outputs registered.
- RUN: prog_mode_s=1 → PROG_IDLE. On entry, set cpu_halt=1, uio_oe_ctrl=0x00 and clear write_count.
- PROG_IDLE:
  - prog_mode_s=0 → EXIT.
  - Otherwise, wr_btn_s=1 → PRESS_DB with the debounce counter cleared.
- PRESS_DB:
  - prog_mode_s=0 → EXIT; no write is issued.
  - wr_btn_s=0 → PROG_IDLE (glitch rejected).
  - Otherwise the counter increments. At DEBOUNCE_CYCLES-1 → WRITE, latching addr_s into ram_addr and data_s into ram_wdata.
- WRITE:
  - ram_we=1.
  - Transfer completes in a cycle with ram_we && ram_ready. Next cycle ram_we=0 and write_count+1 (saturating).
  - Next state is RELEASE_DB, or EXIT if prog_mode_s=0.
  - prog_mode drop never aborts an in-flight write.
  - ram_addr/ram_wdata hold regardless of input changes.
- RELEASE_DB:
  - prog_mode_s=0 → EXIT.
  - Counter counts consecutive wr_btn_s=0 cycles and clears on any 1. At DEBOUNCE_CYCLES-1 → PROG_IDLE.
  - A held button therefore produces exactly one write.
- EXIT: exactly one cycle. cpu_reset_req=1, cpu_halt stays 1. Next state RUN, where cpu_halt=0, cpu_reset_req=0, uio_oe_ctrl=0xFF.
- Latency:
  - The first PROG_IDLE cycle with wr_btn_s=1 is cycle t. ram_we rises at t+DEBOUNCE_CYCLES+1.
  - Pin-to-sync adds SYNC_STAGES cycles.
- Reset mid-write: ram_we drops asynchronously and the write is lost. RAM contents are the RAM's responsibility.
- prog_mode_s=1 while in EXIT: go to RUN anyway. PROG_IDLE is re-entered on the following cycle.

Decomposition:
- Shared package eater_pkg:
  - enum prog_state_t {RUN, PROG_IDLE, PRESS_DB, WRITE, RELEASE_DB, EXIT}.
  - Constants EATER_ADDR_W=4, EATER_DATA_W=8, UIO_OE_RUN=8'hFF, UIO_OE_PROG=8'h00.
- One sub-module input_sync:
  - Parameterized width/stages, async active-low reset.
  - Instantiated once for the {prog_mode, wr_btn, addr, data} bundle.
  - addr/data skew is harmless: they are sampled ≥DEBOUNCE_CYCLES after settling.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst_n=0 with random inputs → ram_we=0, cpu_halt=0, cpu_reset_req=0, write_count=0, uio_oe_ctrl=0xFF. Deassert with prog_mode_in=1 → cpu_halt=1 and uio_oe_ctrl=0x00 within 4 cycles.
- Single write: prog_mode=1, addr=0x3, data=0xA5, ram_ready=1, press held 20 cycles → exactly one ram_we cycle with ram_addr=3, ram_wdata=0xA5, then write_count=1.
- Glitch and repeat:
  - Button high 2 cycles → no ram_we.
  - Release ≥4 cycles, then press with addr=0x4, data=0x1C → one write (4, 0x1C), write_count increments.
  - Bounce during release (0,1,0 pattern) → no second write.
- Back-pressure: ram_ready=0 for 3 cycles after ram_we rises, and data_in changes to 0xFF meanwhile → ram_we high 4 cycles, ram_wdata stays 0xA5, single count increment.
- Exit during write: drop prog_mode while in WRITE with ram_ready=0, then raise ram_ready → write completes, then one-cycle cpu_reset_req=1 with cpu_halt=1; next cycle cpu_halt=0 and uio_oe_ctrl=0xFF.
- Reset mid-operation: assert rst_n=0 while ram_we=1 → ram_we=0 without a clock edge. After release, the FSM restarts in RUN.
